vga_box_compositor: RTL and testbench

Parametrised VGA timing generator and rectangle compositor for the board video path. It generates active-low HS/VS for a configurable mode and draws N_BOX configurable rectangles over a background colour. Each rectangle has per-layer colour and true alpha blending in quarter steps, replacing clock-dithered opacity. A valid/ready configuration port writes a shadow bank that is committed atomically once per frame, so a frame never shows a partial update.

---
 rtl/vga_box_compositor.sv | 181 ++++++++++++++++++
 tb/tb_vga_box_compositor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_box_compositor.sv
// VGA timing generator with N_BOX alpha-blended rectangle layers over a background colour.
// Configuration lands in a pending bank and is committed to the active bank once per frame.
module vga_box_compositor #(
  parameter int COLOR_W  = 4,
  parameter int N_BOX    = 4,
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int IDX_W   = (N_BOX > 1) ? $clog2(N_BOX) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  input  logic [3*COLOR_W-1:0]   bg_rgb,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [CW-1:0]          cfg_x0,
  input  logic [CW-1:0]          cfg_y0,
  input  logic [CW-1:0]          cfg_x1,
  input  logic [CW-1:0]          cfg_y1,
  input  logic [3*COLOR_W-1:0]   cfg_rgb,
  input  logic [2:0]             cfg_alpha,
  input  logic                   cfg_en,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int MW      = COLOR_W + 3;

  logic [CW-1:0] h, v;
  logic          last_h, commit, cfg_we;

  assign last_h    = (h == CW'(H_TOTAL - 1));
  assign commit    = pix_en && last_h && (v == CW'(V_ACTIVE - 1));
  assign cfg_ready = !commit;
  assign cfg_we    = cfg_valid && cfg_ready && (int'(cfg_idx) < N_BOX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (pix_en) begin
      if (last_h) begin
        h <= '0;
        v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  logic [CW-1:0]    p_x0 [N_BOX], p_y0 [N_BOX], p_x1 [N_BOX], p_y1 [N_BOX];
  logic [RGB_W-1:0] p_rgb [N_BOX];
  logic [2:0]       p_alpha [N_BOX];
  logic             p_en [N_BOX];
  logic [CW-1:0]    a_x0 [N_BOX], a_y0 [N_BOX], a_x1 [N_BOX], a_y1 [N_BOX];
  logic [RGB_W-1:0] a_rgb [N_BOX];
  logic [2:0]       a_alpha [N_BOX];
  logic             a_en [N_BOX];

  // Alpha is clamped on the way in so the blend datapath only ever sees 0..4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BOX; i++) begin
        p_x0[i] <= '0;  p_y0[i] <= '0;  p_x1[i] <= '0;  p_y1[i] <= '0;
        p_rgb[i] <= '0; p_alpha[i] <= '0; p_en[i] <= 1'b0;
      end
    end else if (cfg_we) begin
      p_x0[cfg_idx]    <= cfg_x0;
      p_y0[cfg_idx]    <= cfg_y0;
      p_x1[cfg_idx]    <= cfg_x1;
      p_y1[cfg_idx]    <= cfg_y1;
      p_rgb[cfg_idx]   <= cfg_rgb;
      p_alpha[cfg_idx] <= (cfg_alpha > 3'd4) ? 3'd4 : cfg_alpha;
      p_en[cfg_idx]    <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BOX; i++) begin
        a_x0[i] <= '0;  a_y0[i] <= '0;  a_x1[i] <= '0;  a_y1[i] <= '0;
        a_rgb[i] <= '0; a_alpha[i] <= '0; a_en[i] <= 1'b0;
      end
    end else if (commit) begin
      for (int i = 0; i < N_BOX; i++) begin
        a_x0[i] <= p_x0[i];   a_y0[i] <= p_y0[i];
        a_x1[i] <= p_x1[i];   a_y1[i] <= p_y1[i];
        a_rgb[i] <= p_rgb[i]; a_alpha[i] <= p_alpha[i]; a_en[i] <= p_en[i];
      end
    end
  end

  logic [N_BOX-1:0] hit;
  logic             hs_raw, vs_raw, act_raw;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_BOX; i++)
      hit[i] = a_en[i] && (a_x0[i] <= h) && (h < a_x1[i]) && (a_y0[i] <= v) && (v < a_y1[i]);
  end

  assign act_raw = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  assign hs_raw  = !((h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw  = !((v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC)));

  logic [N_BOX-1:0] s1_hit;
  logic             s1_act, s1_hs, s1_vs, s1_first;
  logic [RGB_W-1:0] s1_bg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit   <= '0;
      s1_act   <= 1'b0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_first <= 1'b0;
      s1_bg    <= '0;
    end else if (pix_en) begin
      s1_hit   <= hit;
      s1_act   <= act_raw;
      s1_hs    <= hs_raw;
      s1_vs    <= vs_raw;
      s1_first <= (h == '0) && (v == '0);
      s1_bg    <= bg_rgb;
    end
  end

  // Layers are folded in index order so higher indices land on top.
  logic [RGB_W-1:0] blend;
  logic [MW-1:0]    mix;

  always_comb begin
    blend = s1_bg;
    mix   = '0;
    for (int i = 0; i < N_BOX; i++) begin
      if (s1_hit[i]) begin
        for (int ch = 0; ch < 3; ch++) begin
          mix = MW'(a_alpha[i]) * MW'(a_rgb[i][ch*COLOR_W +: COLOR_W])
              + (MW'(4) - MW'(a_alpha[i])) * MW'(blend[ch*COLOR_W +: COLOR_W]);
          blend[ch*COLOR_W +: COLOR_W] = mix[COLOR_W+1:2];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && s1_first;
      if (pix_en) begin
        vga_r  <= s1_act ? blend[3*COLOR_W-1:2*COLOR_W] : '0;
        vga_g  <= s1_act ? blend[2*COLOR_W-1:COLOR_W]   : '0;
        vga_b  <= s1_act ? blend[COLOR_W-1:0]           : '0;
        vga_hs <= s1_hs;
        vga_vs <= s1_vs;
      end
    end
  end

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor on a reduced video mode so whole frames fit the cycle budget.
module tb_vga_box_compositor;

  localparam int HA = 120, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 24,  VFP = 2, VSY = 2, VBP = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  logic        clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0, pix_toggle = 1'b1;
  logic [11:0] bg_rgb = '0;
  logic        cfg_valid = 1'b0, cfg_en = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_idx = '0;
  logic [9:0]  cfg_x0 = '0, cfg_y0 = '0, cfg_x1 = '0, cfg_y1 = '0;
  logic [11:0] cfg_rgb = '0;
  logic [2:0]  cfg_alpha = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  vga_box_compositor #(
    .COLOR_W(4), .N_BOX(4), .CW(10),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .bg_rgb(bg_rgb),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
    .cfg_rgb(cfg_rgb), .cfg_alpha(cfg_alpha), .cfg_en(cfg_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    pix_en = pix_toggle ? ~pix_en : 1'b1;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [11:0] fb [HA*VA];
  logic        hs_line0 [HT];
  logic        vs_col0 [VT];
  int          blank_nz, hs_low0, vs_low;

  function automatic int fi(input int x, input int y);
    return y * HA + x;
  endfunction

  task automatic wait_frame();
    int g;
    for (g = 0; g < 20000; g++) begin
      @(posedge clk);
      #1;
      if (frame_start) break;
    end
    if (g >= 20000) chk("frame_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < 8; g++) begin
        @(posedge clk);
        if (pix_en) break;
      end
    end
    #1;
  endtask

  task automatic count_fs(output int t);
    t = 0;
    for (int g = 0; g < 20; g++) begin
      @(posedge clk);
      if (pix_en) t++;
      #1;
      if (frame_start) break;
    end
  endtask

  task automatic capture_frame();
    int x, y;
    blank_nz = 0; hs_low0 = 0; vs_low = 0;
    wait_frame();
    for (int n = 0; n < HT * VT; n++) begin
      if (n > 0) wait_ticks(1);
      x = n % HT;
      y = n / HT;
      if (x < HA && y < VA) fb[fi(x, y)] = {vga_r, vga_g, vga_b};
      else if ({vga_r, vga_g, vga_b} != 12'h000) blank_nz++;
      if (y == 0) begin
        hs_line0[x] = vga_hs;
        if (!vga_hs) hs_low0++;
      end
      if (x == 0) vs_col0[y] = vga_vs;
      if (!vga_vs) vs_low++;
    end
  endtask

  task automatic cfg_write(input logic [1:0] idx, input int x0, input int y0, input int x1,
                           input int y1, input logic [11:0] rgb, input logic [2:0] a,
                           input logic en, output int stalls);
    logic acc;
    cfg_idx = idx; cfg_x0 = 10'(x0); cfg_y0 = 10'(y0); cfg_x1 = 10'(x1); cfg_y1 = 10'(y1);
    cfg_rgb = rgb; cfg_alpha = a; cfg_en = en; cfg_valid = 1'b1;
    stalls = 0;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      #1;
      acc = cfg_ready;
      @(posedge clk);
      if (acc) break;
      stalls++;
    end
    #1;
    cfg_valid = 1'b0;
  endtask

  int t, st;

  initial begin
    bg_rgb = 12'h5A3;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    count_fs(t);
    chk("first_fs_ticks", t, 2);

    capture_frame();
    chk("hs_low_ticks", hs_low0, HSY);
    chk("vs_low_ticks", vs_low, VSY * HT);
    chk("hs_edge_low", hs_line0[HA + HFP], 0);
    chk("hs_edge_high", hs_line0[HA + HFP - 1], 1);
    chk("vs_edge_low", vs_col0[VA + VFP], 0);
    chk("vs_edge_high", vs_col0[VA + VFP - 1], 1);
    chk("bg_first", fb[fi(0, 0)], 12'h5A3);
    chk("bg_last", fb[fi(HA - 1, VA - 1)], 12'h5A3);
    chk("blank_zero0", blank_nz, 0);

    pix_toggle = 1'b0;
    bg_rgb = 12'h222;
    wait_frame();
    cfg_write(0, 100, 10, 118, 20, 12'hFFF, 3'd4, 1'b1, st);
    capture_frame();
    chk("opaque_in", fb[fi(100, 12)], 12'hFFF);
    chk("opaque_left", fb[fi(99, 12)], 12'h222);
    chk("opaque_x1", fb[fi(118, 12)], 12'h222);
    chk("opaque_y1", fb[fi(100, 20)], 12'h222);

    bg_rgb = 12'h000;
    wait_frame();
    cfg_write(0, 10, 2, 30, 12, 12'hF00, 3'd4, 1'b1, st);
    cfg_write(1, 20, 6, 40, 16, 12'h00F, 3'd2, 1'b1, st);
    capture_frame();
    chk("overlap", fb[fi(25, 8)], 12'h707);
    chk("layer1_only", fb[fi(35, 14)], 12'h007);
    chk("layer0_only", fb[fi(15, 4)], 12'hF00);
    chk("outside", fb[fi(5, 5)], 12'h000);

    bg_rgb = 12'h123;
    wait_frame();
    cfg_write(0, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0, st);
    cfg_write(1, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0, st);
    cfg_write(2, 0, 0, 1023, 1023, 12'h888, 3'd7, 1'b1, st);
    cfg_write(3, 50, 0, 50, 24, 12'hFFF, 3'd4, 1'b1, st);
    capture_frame();
    chk("alpha7_full", fb[fi(10, 5)], 12'h888);
    chk("x1_eq_x0", fb[fi(50, 5)], 12'h888);
    chk("corner", fb[fi(HA - 1, VA - 1)], 12'h888);
    chk("blank_zero_box", blank_nz, 0);

    wait_frame();
    cfg_write(2, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0, st);
    cfg_write(3, 0, 0, 0, 0, 12'h000, 3'd0, 1'b0, st);
    capture_frame();
    chk("cleared", fb[fi(10, 20)], 12'h123);
    fork
      capture_frame();
      begin
        wait_frame();
        wait_ticks(12 * HT);
        cfg_write(0, 0, 0, 60, 24, 12'hFFF, 3'd4, 1'b1, st);
      end
    join
    chk("atomic_cur_top", fb[fi(10, 0)], 12'h123);
    chk("atomic_cur_low", fb[fi(10, 20)], 12'h123);
    capture_frame();
    chk("atomic_next_top", fb[fi(10, 0)], 12'hFFF);
    chk("atomic_next_low", fb[fi(10, 20)], 12'hFFF);

    wait_frame();
    wait_ticks(VA * HT - 3);
    chk("ready_low_commit", cfg_ready, 0);
    cfg_write(1, 0, 0, 60, 24, 12'h0F0, 3'd4, 1'b1, st);
    chk("commit_stalls", st, 1);
    capture_frame();
    chk("late_write_held", fb[fi(10, 5)], 12'hFFF);
    capture_frame();
    chk("late_write_seen", fb[fi(10, 5)], 12'h0F0);

    wait_frame();
    wait_ticks(20 * HT + 10);
    chk("pre_reset_px", {vga_r, vga_g, vga_b}, 12'h0F0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("mid_rst_hs", vga_hs, 1);
    chk("mid_rst_vs", vga_vs, 1);
    chk("mid_rst_ready", cfg_ready, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_fs(t);
    chk("restart_fs_ticks", t, 2);
    capture_frame();
    chk("boxes_gone", fb[fi(10, 5)], 12'h123);
    chk("boxes_gone2", fb[fi(25, 8)], 12'h123);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
